hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/pipe_pkg.sv | 19 +
 rtl/hazard_fwd_sel.sv | 23 ++
 rtl/hazard_unit.sv | 147 ++++++++++++++
 tb/tb_hazard_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings for the hazard unit: FSM states, ResultSrc and
// forward-select codes.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERR   = 2'd2
  } state_e;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// One Execute-operand forward select. The Memory stage wins over Writeback
// because it holds the younger value. x0 is never forwarded.
module hazard_fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  // priority select: Memory, then Writeback, else register file
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e))
      fwd = FWD_MEM;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e))
      fwd = FWD_WB;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and
// data-memory wait handling with a timeout error state.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters;
// without it StallCnt/FlushCnt read as zero.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemErr,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;
  logic            lw_stall, mem_wait, in_err;

  hazard_fwd_sel u_fwd_a (
    .rs_e(Rs1E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(ForwardAE)
  );

  hazard_fwd_sel u_fwd_b (
    .rs_e(Rs2E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(ForwardBE)
  );

  assign in_err   = (state_q == ERR);
  assign lw_stall = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_wait = MemReqM && !MemReadyM && !in_err;

  // next state and consecutive-wait counter; the Nth wait edge enters ERR
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    if (in_err) begin
      state_d = ERR;
    end else if (mem_wait) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
      state_d    = (wait_cnt_q == CW'(MEM_TIMEOUT - 1)) ? ERR : MWAIT;
    end else begin
      state_d = RUN;
    end
    mem_err_d = (state_d == ERR);
  end

  // FSM, wait counter and sticky error flop
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign MemErr = mem_err_q;

  // stall/flush priority: reset, ERR/memory wait, taken branch, load-use
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (RST) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (in_err || mem_wait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (PCSrcE) begin
      // wrong-path Decode instruction is discarded, so no load-use stall
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (FlushD && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // counter flops; reset holds them at zero
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = 32'd0;
  assign FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (MEM_TIMEOUT 16 and 4) share inputs.
// Stimulus pushes hand-computed expectations; a monitor pops one per cycle.
module tb_hazard_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;

  logic        sfa, sda, sea, sma, fda, fea, mea;
  logic        sfb, sdb, seb, smb, fdb, feb, meb;
  logic [1:0]  faa, fba, fab, fbb;
  logic [31:0] sca, fca, scb, fcb;

  always #5 CLK = ~CLK;

  hazard_unit #(.MEM_TIMEOUT(16)) dut_a (
    .CLK(CLK), .RST(RST), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM),
    .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .StallF(sfa), .StallD(sda), .StallE(sea), .StallM(sma),
    .FlushD(fda), .FlushE(fea), .ForwardAE(faa), .ForwardBE(fba), .MemErr(mea),
    .StallCnt(sca), .FlushCnt(fca)
  );

  hazard_unit #(.MEM_TIMEOUT(4)) dut_b (
    .CLK(CLK), .RST(RST), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM),
    .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .StallF(sfb), .StallD(sdb), .StallE(seb), .StallM(smb),
    .FlushD(fdb), .FlushE(feb), .ForwardAE(fab), .ForwardBE(fbb), .MemErr(meb),
    .StallCnt(scb), .FlushCnt(fcb)
  );

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] EXP_SC = 32'd5;
  localparam logic [31:0] EXP_FC = 32'd2;
`else
  localparam logic [31:0] EXP_SC = 32'd0;
  localparam logic [31:0] EXP_FC = 32'd0;
`endif

  // {ForwardAE, ForwardBE, StallF,D,E,M, FlushD,E, MemErr}
  typedef struct {
    string       nm;
    logic [10:0] ea;
    logic [10:0] eb;
    bit          cc;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [10:0] ex(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [3:0] st, input logic [1:0] fl,
                                     input logic me);
    return {fa, fb, st, fl, me};
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // monitor: one expectation per cycle, sampled on the falling edge
  initial begin
    exp_t e;
    logic [10:0] oa, ob;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e  = q.pop_front();
        oa = {faa, fba, sfa, sda, sea, sma, fda, fea, mea};
        ob = {fab, fbb, sfb, sdb, seb, smb, fdb, feb, meb};
        total++;
        if (oa !== e.ea) begin
          bad++;
          $display("FAIL %s dutA got=%b exp=%b", e.nm, oa, e.ea);
        end
        total++;
        if (ob !== e.eb) begin
          bad++;
          $display("FAIL %s dutB got=%b exp=%b", e.nm, ob, e.eb);
        end
        if (e.cc) begin
          chk32({e.nm, " StallCntA"}, sca, e.sc);
          chk32({e.nm, " FlushCntA"}, fca, e.fc);
          chk32({e.nm, " StallCntB"}, scb, e.sc);
          chk32({e.nm, " FlushCntB"}, fcb, e.fc);
        end
      end
    end
  end

  task automatic step(input string nm, input logic [10:0] ea, input logic [10:0] eb,
                      input bit cc = 1'b0, input logic [31:0] sc = 0, input logic [31:0] fc = 0);
    exp_t e;
    e.nm = nm; e.ea = ea; e.eb = eb; e.cc = cc; e.sc = sc; e.fc = fc;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  localparam logic [3:0] S0 = 4'b0000, SLW = 4'b1100, SALL = 4'b1111;
  localparam logic [1:0] F0 = 2'b00, FE = 2'b01, FDE = 2'b11;

  initial begin
    RST = 1'b1;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00;
    {PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM} = '0;
    @(posedge CLK);
    #1;
    step("reset", ex(0, 0, S0, FDE, 0), ex(0, 0, S0, FDE, 0), 1'b1, 0, 0);
    RST = 1'b0;

    // load-use stalls and branch flushes (feed the perf counters)
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    step("lw_rs2", ex(0, 0, SLW, FE, 0), ex(0, 0, SLW, FE, 0));
    RdE = 0;
    step("lw_rd0", ex(0, 0, S0, F0, 0), ex(0, 0, S0, F0, 0));
    RdE = 7; Rs2D = 0; Rs1D = 7;
    step("lw_rs1", ex(0, 0, SLW, FE, 0), ex(0, 0, SLW, FE, 0));
    ResultSrcE = 2'b00;
    step("alu_nostall", ex(0, 0, S0, F0, 0), ex(0, 0, S0, F0, 0));
    ResultSrcE = 2'b01;
    step("lw_3", ex(0, 0, SLW, FE, 0), ex(0, 0, SLW, FE, 0));
    step("lw_4", ex(0, 0, SLW, FE, 0), ex(0, 0, SLW, FE, 0));
    step("lw_5", ex(0, 0, SLW, FE, 0), ex(0, 0, SLW, FE, 0));
    PCSrcE = 1'b1;
    step("br_over_lw", ex(0, 0, S0, FDE, 0), ex(0, 0, S0, FDE, 0));
    ResultSrcE = 2'b00;
    step("br", ex(0, 0, S0, FDE, 0), ex(0, 0, S0, FDE, 0));
    PCSrcE = 1'b0; RdE = 0; Rs1D = 0;
    step("perf_cnt", ex(0, 0, S0, F0, 0), ex(0, 0, S0, F0, 0), 1'b1, EXP_SC, EXP_FC);

    // forwarding
    Rs1E = 5; Rs2E = 3; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    step("fwd_mem", ex(2'b10, 0, S0, F0, 0), ex(2'b10, 0, S0, F0, 0));
    RegWriteM = 0;
    step("fwd_wb", ex(2'b01, 0, S0, F0, 0), ex(2'b01, 0, S0, F0, 0));
    RegWriteM = 1; RdM = 0; RdW = 0;
    step("fwd_x0", ex(0, 0, S0, F0, 0), ex(0, 0, S0, F0, 0));
    Rs1E = 0; Rs2E = 9; RdM = 9; RegWriteM = 0; RdW = 9;
    step("fwdb_wb", ex(0, 2'b01, S0, F0, 0), ex(0, 2'b01, S0, F0, 0));
    RegWriteM = 1;
    step("fwdb_mem", ex(0, 2'b10, S0, F0, 0), ex(0, 2'b10, S0, F0, 0));
    {Rs2E, RdM, RdW, RegWriteM, RegWriteW} = '0;

    // short memory wait, with a branch losing to it
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    step("mw1_br", ex(0, 0, SALL, F0, 0), ex(0, 0, SALL, F0, 0));
    PCSrcE = 0;
    step("mw2", ex(0, 0, SALL, F0, 0), ex(0, 0, SALL, F0, 0));
    step("mw3", ex(0, 0, SALL, F0, 0), ex(0, 0, SALL, F0, 0));
    MemReadyM = 1;
    step("mw_done", ex(0, 0, S0, F0, 0), ex(0, 0, S0, F0, 0));
    MemReqM = 0;
    step("mw_idle", ex(0, 0, S0, F0, 0), ex(0, 0, S0, F0, 0));

    // timeout: dut_b (4) reaches ERR, dut_a (16) keeps waiting
    MemReqM = 1; MemReadyM = 0;
    for (int i = 1; i <= 4; i++)
      step($sformatf("to_w%0d", i), ex(0, 0, SALL, F0, 0), ex(0, 0, SALL, F0, 0));
    step("to_err", ex(0, 0, SALL, F0, 0), ex(0, 0, SALL, F0, 1));
    MemReadyM = 1;
    step("err_hold_rdy", ex(0, 0, S0, F0, 0), ex(0, 0, SALL, F0, 1));
    MemReqM = 0; PCSrcE = 1;
    step("err_over_br", ex(0, 0, S0, FDE, 0), ex(0, 0, SALL, F0, 1));
    PCSrcE = 0; RST = 1;
    step("err_rst", ex(0, 0, S0, FDE, 0), ex(0, 0, S0, FDE, 1));
    RST = 0;
    step("err_clr", ex(0, 0, S0, F0, 0), ex(0, 0, S0, F0, 0), 1'b1, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge CLK);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog time=%0t limit=20000", $time);
    $fatal(1, "watchdog");
  end

endmodule
